uart_tx_fifo_feeder: RTL
========================

Name: uart_tx_fifo_feeder

Overview:
- Byte FIFO plus launch state machine sitting directly upstream of the UART transmitter inside the UART top level.
- Accepts bytes from the host side with a write strobe and buffers up to DEPTH entries.
- Presents one byte at a time to the transmitter's data_in/transmit inputs, using the transmitter's TX_active output as the busy handshake.
- Lets software queue a burst without polling TX_active per byte.

Parameters:
DATA_W, 8, byte width, matches transmitter data_in
ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W = 16 entries

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
wr_en  input  1  host write strobe, one byte per cycle
wr_data  input  DATA_W  host write byte
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  ADDR_W+1  current entry count, 0..DEPTH
tx_data  output  DATA_W  byte to transmitter data_in
tx_start  output  1  to transmitter transmit input
tx_active  input  1  transmitter TX_active, high while a frame is on the line

Behaviour:
- Reset (reset==0 at rising edge) forces the following, and has priority over all other activity:
  - rd/wr pointers = 0, level = 0, empty = 1, full = 0
  - tx_data = 0, tx_start = 0, state = IDLE
- Reset mid-transfer: queued and in-flight bytes are discarded; the transmitter finishes its frame independently.
- Write: accepted when wr_en==1 and full==0. Store at wr_ptr, wr_ptr+1, level+1.
- Write while full is dropped silently. Full is evaluated before any same-cycle pop, so a write is rejected even if a pop occurs that cycle.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally. level is ADDR_W+1 bits. full = (level==DEPTH), empty = (level==0), both registered-consistent with level.
- Simultaneous accepted write and pop: level unchanged, both pointers advance.
- FSM states:
  - IDLE: if empty==0 and tx_active==0, pop head into tx_data, rd_ptr+1, level-1, tx_start <= 1, go START. Otherwise stay.
  - START: hold tx_start=1 and tx_data stable until tx_active==1 is sampled. Then tx_start <= 0, go BUSY. No timeout.
  - BUSY: wait for tx_active==0, then go IDLE.
- IDLE gating on tx_active ensures no launch while a frame from before reset is still active.
- tx_data changes only on a pop; it holds its value through BUSY and IDLE.
- Latency: write sampled at edge E into an empty FIFO with FSM in IDLE and tx_active low -> tx_start and tx_data valid after edge E+1.
- Back-to-back bytes: at least one IDLE cycle between tx_active falling and the next tx_start rising.
- Write into an empty FIFO on the same edge the FSM evaluates IDLE: no pop that edge; the byte pops next edge.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN
- When defined:
  - Adds output ovf (1 bit) and input ovf_clr (1 bit).
  - ovf is set on any cycle with wr_en==1 and full==1, and stays set until ovf_clr==1 is sampled. Set wins over a same-cycle clear.
  - Reset value 0.
- When undefined: ports absent, overflowing writes dropped with no indication.

Test Plan:
- Single byte: after reset, write 8'hAC with a transmitter model raising tx_active 3 cycles after tx_start -> tx_start high after edge E+1 with tx_data=8'hAC, held until tx_active seen; level returns to 0; empty=1.
- Burst: write 8'h01..8'h05 on consecutive cycles -> transmitter receives 01,02,03,04,05 in order, one tx_start per byte, each only after the previous tx_active falls.
- Full/wrap: with tx_active stuck high, write 17 bytes -> level=16, full=1, 17th dropped (ovf=1 when UART_TX_FIFO_OVF_EN is defined). Release tx_active, then write 8 more bytes after draining -> pointer wrap yields correct order.
- Simultaneous write/pop: FIFO level 3, write on the pop edge -> level stays 3, no byte lost or duplicated.
- Reset mid-operation: assert reset low for 1 cycle during BUSY with 4 bytes queued -> level=0, tx_start=0, tx_data=0. A subsequent write is not launched until tx_active goes low.
- Overflow clear (macro defined): ovf=1, pulse ovf_clr -> ovf=0 next cycle. ovf_clr coincident with an overflowing write -> ovf stays 1.

Source files
------------

// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO plus launch FSM feeding a UART transmitter; optional overflow flag via UART_TX_FIFO_OVF_EN
module uart_tx_fifo_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_active
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, empty_q, tx_start_q, tx_start_d, push, pop;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  // full is the pre-pop value, so a write is refused even when a pop frees a slot that cycle
  assign push = wr_en && !full_q;
  // launch FSM: pop only when idle, data queued and the line is quiet
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty_q && !tx_active) begin
        pop        = 1'b1;
        tx_start_d = 1'b1;
        state_d    = START;
      end
      START: if (tx_active) begin
        tx_start_d = 1'b0;
        state_d    = BUSY;
      end
      BUSY: state_d = tx_active ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    level_d   = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end
  // storage array needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= wr_data;
  end
  // pointers, occupancy flags and transmitter handshake registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_q + ADDR_W'(push);
      rd_ptr_q   <= rd_ptr_q + ADDR_W'(pop);
      level_q    <= level_d;
      full_q     <= level_d == (ADDR_W+1)'(DEPTH);
      empty_q    <= level_d == '0;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;
  // sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) ovf_q <= 1'b0;
    else if (wr_en && full_q) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end
  assign ovf = ovf_q;
`endif
endmodule
